// File: rtl/fb_scan_arbiter_pkg.sv
// Shared constants for the framebuffer board sampler: FSM encoding,
// framebuffer geometry defaults and tile sampling geometry.
package fb_scan_arbiter_pkg;

   localparam int ADDR_W = 15;

   typedef logic [ADDR_W-1:0] fb_addr_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int FB_W_DEF    = 160;
   localparam int TILE        = 8;
   localparam int SAMPLE_OFS  = 4;
   localparam int CELLS_X_DEF = 10;
   localparam int CELLS_Y_DEF = 18;

endpackage

// File: rtl/fb_cell_addr_gen.sv
// Row-major walk over the playfield tiles, producing the framebuffer address
// of each tile's centre pixel using only adders.
module fb_cell_addr_gen
   import fb_scan_arbiter_pkg::*;
#(
   parameter int FB_W     = FB_W_DEF,
   parameter int BOARD_X0 = 16,
   parameter int BOARD_Y0 = 0,
   parameter int CELLS_X  = CELLS_X_DEF,
   parameter int CELLS_Y  = CELLS_Y_DEF
) (
   input  logic     clk,
   input  logic     clear,
   input  logic     advance,
   output fb_addr_t addr,
   output logic     last
);

   localparam int CW = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
   localparam int RW = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;

   localparam fb_addr_t BASE     = fb_addr_t'((BOARD_Y0 + SAMPLE_OFS) * FB_W + BOARD_X0 + SAMPLE_OFS);
   localparam fb_addr_t COL_STEP = fb_addr_t'(TILE);
   // Moving from the last column back to column 0 one tile row down.
   localparam fb_addr_t ROW_STEP = fb_addr_t'(TILE * FB_W - (CELLS_X - 1) * TILE);
   localparam logic [CW-1:0] COL_LAST = CW'(CELLS_X - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(CELLS_Y - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   fb_addr_t      addr_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         col    <= '0;
         row    <= '0;
         addr_q <= BASE;
      end else if (advance) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
               row    <= '0;
               addr_q <= BASE;
            end else begin
               row    <= row + 1'b1;
               addr_q <= addr_q + ROW_STEP;
            end
         end else begin
            col    <= col + 1'b1;
            addr_q <= addr_q + COL_STEP;
         end
      end
   end

   // Cell 0 is presented while clear is held, not only after the next edge.
   assign addr = clear ? BASE : addr_q;
   assign last = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/fb_scan_arbiter.sv
// Shares the framebuffer read port between VGA refresh and a background
// sampler that snapshots tile occupancy of the playfield into `board`.
module fb_scan_arbiter
   import fb_scan_arbiter_pkg::*;
#(
   parameter int         FB_W        = FB_W_DEF,
   parameter int         BOARD_X0    = 16,
   parameter int         BOARD_Y0    = 0,
   parameter int         CELLS_X     = CELLS_X_DEF,
   parameter int         CELLS_Y     = CELLS_Y_DEF,
   parameter logic [1:0] EMPTY_SHADE = 2'b00
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       vga_req,
   input  logic [14:0]                vga_addr,
   output logic [14:0]                fb_addr,
   input  logic [1:0]                 fb_q,
   input  logic                       scan_start,
   output logic                       scan_busy,
   output logic                       scan_done,
   output logic [CELLS_X*CELLS_Y-1:0] board,
   output logic [1:0]                 state_dbg
);

   localparam int N = CELLS_X * CELLS_Y;

   logic [1:0]   state, state_nx;
   logic         issue;
   logic         pend;
   logic         cap_bit;
   logic         gen_last;
   fb_addr_t     samp_addr;
   logic [N-1:0] shadow, shadow_nx;

   fb_cell_addr_gen #(
      .FB_W     (FB_W),
      .BOARD_X0 (BOARD_X0),
      .BOARD_Y0 (BOARD_Y0),
      .CELLS_X  (CELLS_X),
      .CELLS_Y  (CELLS_Y)
   ) u_addr_gen (
      .clk     (clk),
      .clear   (reset),
      .advance (issue),
      .addr    (samp_addr),
      .last    (gen_last)
   );

   // Port sharing: vga_req is a request with no ready back-channel; it always
   // wins the port that cycle, and the sampler simply does not issue.
   assign fb_addr = vga_req ? vga_addr : samp_addr;

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      case (state)
         ST_IDLE:  if (scan_start) state_nx = ST_SCAN;
         ST_SCAN: begin
            if (!vga_req) begin
               issue = 1'b1;
               if (gen_last) state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: state_nx = ST_DONE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Cells are captured in index order, so shifting in at the top leaves
   // cell 0 at bit 0 after the final capture.
   assign cap_bit   = (fb_q != EMPTY_SHADE);
   assign shadow_nx = pend ? {cap_bit, shadow[N-1:1]} : shadow;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         pend   <= 1'b0;
         shadow <= '0;
         board  <= '0;
      end else begin
         state  <= state_nx;
         pend   <= issue;
         shadow <= shadow_nx;
         if (state_nx == ST_DONE) board <= shadow_nx;
      end
   end

   assign scan_busy = (state == ST_SCAN) || (state == ST_DRAIN);
   assign scan_done = (state == ST_DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Self-checking bench for fb_scan_arbiter: framebuffer memory model, tile
// occupancy reference model, table-driven and randomized scans.
module tb_fb_scan_arbiter;
   import fb_scan_arbiter_pkg::*;

   localparam int FBW = 160;
   localparam int BX0 = 16;
   localparam int BY0 = 0;
   localparam int CX  = 10;
   localparam int CY  = 18;
   localparam int NC  = CX * CY;

   logic          clk = 1'b0;
   logic          reset;
   logic          vga_req;
   logic [14:0]   vga_addr;
   logic [14:0]   fb_addr;
   logic [1:0]    fb_q;
   logic          scan_start;
   logic          scan_busy;
   logic          scan_done;
   logic [NC-1:0] board;
   logic [1:0]    state_dbg;

   logic [1:0]    fb_mem [0:32767];

   int checks = 0;
   int errors = 0;

   fb_scan_arbiter #(
      .FB_W(FBW), .BOARD_X0(BX0), .BOARD_Y0(BY0),
      .CELLS_X(CX), .CELLS_Y(CY), .EMPTY_SHADE(2'b00)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .vga_req    (vga_req),
      .vga_addr   (vga_addr),
      .fb_addr    (fb_addr),
      .fb_q       (fb_q),
      .scan_start (scan_start),
      .scan_busy  (scan_busy),
      .scan_done  (scan_done),
      .board      (board),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock / framebuffer memory ----------------
   always #5 clk = ~clk;

   always @(posedge clk) fb_q <= fb_mem[fb_addr];

   // ---------------- reference model ----------------
   function automatic int cell_addr(input int idx);
      int r, c;
      r = idx / CX;
      c = idx % CX;
      return (BY0 + r * 8 + 4) * FBW + (BX0 + c * 8 + 4);
   endfunction

   function automatic logic [NC-1:0] model_board();
      logic [NC-1:0] b;
      for (int i = 0; i < NC; i++) b[i] = (fb_mem[cell_addr(i)] != 2'b00);
      return b;
   endfunction

   // ---------------- checkers ----------------
   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic chk_vec(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic fb_clear();
      for (int a = 0; a < 32768; a++) fb_mem[a] = 2'b00;
   endtask

   task automatic fb_rand();
      for (int a = 0; a < 32768; a++) fb_mem[a] = 2'($urandom_range(0, 3));
   endtask

   function automatic logic pick_vga(input int mode, input int c);
      case (mode)
         1:       return (c % 2) == 1;
         2:       return $urandom_range(0, 99) < 30;
         3:       return (c >= 50) && (c < 1050);
         default: return 1'b0;
      endcase
   endfunction

   // mode 0: no VGA, 1: VGA on odd cycles, 2: random VGA,
   // 3: VGA held 1000 cycles from cycle 50, 4: no VGA plus stray scan_start pulses
   task automatic run_scan(input int mode, input string tag);
      logic [NC-1:0] exp_board, prev_board;
      int issues, exp_lat, c;
      bit done_seen;
      exp_board = model_board();
      prev_board = board;
      issues = 0;
      exp_lat = -1;
      done_seen = 0;
      @(negedge clk);
      scan_start = 1'b1;
      vga_req = 1'b0;
      @(negedge clk);
      scan_start = 1'b0;
      for (c = 0; c < 3000; c++) begin
         if (scan_done) begin
            done_seen = 1;
            break;
         end
         chk_int({tag, "_busy"}, int'(scan_busy), 1);
         chk_vec({tag, "_board_hold"}, board, prev_board);
         vga_req = pick_vga(mode, c);
         vga_addr = 15'($urandom_range(0, 32767));
         scan_start = (mode == 4) && (c == 20 || c == 100);
         #1;
         if (vga_req) chk_int({tag, "_vga_pass"}, int'(fb_addr), int'(vga_addr));
         else if (issues < NC) begin
            chk_int({tag, "_cell_addr"}, int'(fb_addr), cell_addr(issues));
            issues++;
            if (issues == NC) exp_lat = c + 3;
         end
         @(negedge clk);
      end
      vga_req = 1'b0;
      scan_start = 1'b0;
      if (!done_seen) begin
         chk_int({tag, "_timeout"}, 0, 1);
      end else begin
         chk_int({tag, "_latency"}, c + 1, exp_lat);
         chk_int({tag, "_busy_at_done"}, int'(scan_busy), 0);
         chk_int({tag, "_state_done"}, int'(state_dbg), int'(ST_DONE));
         chk_vec({tag, "_board"}, board, exp_board);
         @(negedge clk);
         chk_int({tag, "_done_pulse"}, int'(scan_done), 0);
         chk_int({tag, "_state_idle"}, int'(state_dbg), int'(ST_IDLE));
         chk_vec({tag, "_board_kept"}, board, exp_board);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int         pix_addr;
      logic [1:0] pix_val;
      int         vga_mode;
      int         exp_bit;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic [NC-1:0] exp_b;
      vecs[0] = '{660,   2'd1, 0, 0};
      vecs[1] = '{22492, 2'd3, 0, 179};
      vecs[2] = '{661,   2'd2, 0, -1};
      vecs[3] = '{1940,  2'd2, 0, 10};
      vecs[4] = '{732,   2'd1, 0, 9};
      vecs[5] = '{660,   2'd1, 1, 0};
      vecs[6] = '{660,   2'd1, 3, 0};
      vecs[7] = '{22492, 2'd3, 4, 179};

      reset = 1'b1;
      vga_req = 1'b0;
      vga_addr = '0;
      scan_start = 1'b0;
      fb_clear();
      repeat (3) @(negedge clk);
      chk_vec("rst_board", board, '0);
      chk_int("rst_busy", int'(scan_busy), 0);
      chk_int("rst_done", int'(scan_done), 0);
      chk_int("rst_state", int'(state_dbg), int'(ST_IDLE));
      chk_int("rst_fb_addr", int'(fb_addr), 660);
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         fb_clear();
         fb_mem[vecs[v].pix_addr] = vecs[v].pix_val;
         exp_b = '0;
         if (vecs[v].exp_bit >= 0) exp_b[vecs[v].exp_bit] = 1'b1;
         run_scan(vecs[v].vga_mode, $sformatf("vec%0d", v));
         chk_vec($sformatf("vec%0d_table_board", v), board, exp_b);
      end

      // Reset 50 cycles into a scan, with a nonzero board beforehand.
      fb_rand();
      fb_mem[660] = 2'd1;
      run_scan(0, "pre_rst");
      @(negedge clk);
      scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
      repeat (50) @(negedge clk);
      chk_int("mid_busy", int'(scan_busy), 1);
      reset = 1'b1;
      #1;
      chk_int("mid_rst_fb_addr", int'(fb_addr), 660);
      @(negedge clk);
      reset = 1'b0;
      chk_int("mid_rst_state", int'(state_dbg), int'(ST_IDLE));
      chk_vec("mid_rst_board", board, '0);
      chk_int("mid_rst_busy", int'(scan_busy), 0);
      chk_int("mid_rst_done", int'(scan_done), 0);
      repeat (3) @(negedge clk);
      chk_int("post_rst_idle", int'(state_dbg), int'(ST_IDLE));

      for (int r = 0; r < 4; r++) begin
         fb_rand();
         run_scan(2, $sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
